// File: rtl/wave_meas_pkg.sv
// Shared types and widths for the waveform-measurement sequencer.
// Holds the state/wave-type enums, the result payload and the PAPR classifier.
package wave_meas_pkg;

  localparam int unsigned ADC_W  = 8;
  localparam int unsigned MS_W   = 16;
  localparam int unsigned SUM_W  = 24;
  localparam int unsigned PAPR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PEAK,
    CALC1,
    RMS,
    CALC2,
    DIV,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    WT_NONE   = 2'd0,
    WT_SINE   = 2'd1,
    WT_SQUARE = 2'd2,
    WT_TRI    = 2'd3
  } wave_type_e;

  typedef struct packed {
    logic [ADC_W-1:0]  vpp;
    logic [ADC_W-1:0]  dc_offset;
    logic [MS_W-1:0]   mean_sq;
    logic [PAPR_W-1:0] papr;
    wave_type_e        wave_type;
  } meas_result_t;

  // Inclusive PAPR windows; a flat signal (ms == 0) is always unknown.
  function automatic wave_type_e classify(
    input logic [PAPR_W-1:0] papr,
    input logic              ms_zero,
    input int unsigned       sq_lo,
    input int unsigned       sq_hi,
    input int unsigned       sine_lo,
    input int unsigned       sine_hi,
    input int unsigned       tri_lo,
    input int unsigned       tri_hi
  );
    int unsigned p;
    p = 32'(papr);
    if (ms_zero)                          return WT_NONE;
    else if (p >= sq_lo && p <= sq_hi)     return WT_SQUARE;
    else if (p >= sine_lo && p <= sine_hi) return WT_SINE;
    else if (p >= tri_lo && p <= tri_hi)   return WT_TRI;
    else                                   return WT_NONE;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// 16/16 restoring divider, one quotient bit per cycle; div_done pulses
// 16 cycles after div_start. Kept standalone so other blocks can share it.
module seq_divider
  import wave_meas_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_start,
  input  logic [MS_W-1:0] dividend,
  input  logic [MS_W-1:0] divisor,
  output logic            div_done,
  output logic [MS_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(MS_W);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MS_W-1:0]  quo_q, quo_d;
  logic [MS_W-1:0]  dsr_q, dsr_d;
  logic [MS_W-1:0]  rem_q, rem_d;
  logic [MS_W:0]    shifted;
  logic [MS_W:0]    trial;

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    shifted = {rem_q, quo_q[MS_W-1]};
    trial   = shifted - {1'b0, dsr_q};
    if (div_start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      dsr_d  = divisor;
      rem_d  = '0;
    end else if (busy_q) begin
      // Sign bit of the trial subtraction decides restore vs keep.
      if (trial[MS_W]) begin
        rem_d = shifted[MS_W-1:0];
        quo_d = {quo_q[MS_W-2:0], 1'b0};
      end else begin
        rem_d = trial[MS_W-1:0];
        quo_d = {quo_q[MS_W-2:0], 1'b1};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(MS_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
    end
  end

  assign div_done = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/wave_measure_ctrl.sv
// Scheduled peak / mean-square / PAPR / classify cycle on the ADC stream.
// Define CONT_MEAS_EN for back-to-back measurements without a new start.
module wave_measure_ctrl
  import wave_meas_pkg::*;
#(
  parameter int unsigned FRE_DIV = 1249,
  parameter int unsigned LOG2_N  = 6,
  parameter int unsigned SQ_LO   = 3,
  parameter int unsigned SQ_HI   = 5,
  parameter int unsigned SINE_LO = 6,
  parameter int unsigned SINE_HI = 9,
  parameter int unsigned TRI_LO  = 10,
  parameter int unsigned TRI_HI  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              busy,
  output logic              done,
  output logic [ADC_W-1:0]  vpp,
  output logic [ADC_W-1:0]  dc_offset,
  output logic [MS_W-1:0]   mean_sq,
  output logic [PAPR_W-1:0] papr,
  output logic [1:0]        wave_type
);

  localparam int unsigned STB_W  = (FRE_DIV > 0) ? $clog2(FRE_DIV + 1) : 1;
  localparam int unsigned SCNT_W = LOG2_N + 1;
  localparam int unsigned N_SAMP = 1 << LOG2_N;
  localparam int unsigned PROD_W = 2 * ADC_W + 2;

  state_e             state_q, state_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [ADC_W-1:0]   max_q, max_d;
  logic [ADC_W-1:0]   min_q, min_d;
  logic [ADC_W-1:0]   vpp_int_q, vpp_int_d;
  logic [ADC_W-1:0]   dc_int_q, dc_int_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [MS_W-1:0]    ms_q, ms_d;
  meas_result_t       res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_start_q, div_start_d;

  logic               strobe;
  logic               last_samp;
  logic signed [PROD_W-1:0] diff;
  logic signed [PROD_W-1:0] sq;
  logic [MS_W-1:0]    ms_now;
  logic [PAPR_W-1:0]  papr_sat;
  logic               div_done;
  logic [MS_W-1:0]    quotient;
  logic [MS_W-1:0]    dividend;

  assign strobe    = (stb_cnt_q == STB_W'(FRE_DIV));
  assign last_samp = (scnt_q == SCNT_W'(N_SAMP - 1));
  assign diff      = $signed(PROD_W'(adc_data)) - $signed(PROD_W'(dc_int_q));
  assign sq        = diff * diff;
  assign ms_now    = MS_W'(sum_q >> LOG2_N);
  assign papr_sat  = (quotient > MS_W'(255)) ? {PAPR_W{1'b1}} : quotient[PAPR_W-1:0];
  assign dividend  = MS_W'(vpp_int_q) * MS_W'(vpp_int_q);

  seq_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_start (div_start_q),
    .dividend  (dividend),
    .divisor   (ms_q),
    .div_done  (div_done),
    .quotient  (quotient)
  );

  // Next-state and datapath; abort overrides every in-flight event.
  always_comb begin
    state_d     = state_q;
    stb_cnt_d   = strobe ? '0 : stb_cnt_q + STB_W'(1);
    scnt_d      = scnt_q;
    max_d       = max_q;
    min_d       = min_q;
    vpp_int_d   = vpp_int_q;
    dc_int_d    = dc_int_q;
    sum_d       = sum_q;
    ms_d        = ms_q;
    res_d       = res_q;
    done_d      = 1'b0;
    div_start_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = PEAK;
            stb_cnt_d = '0;
            scnt_d    = '0;
            max_d     = '0;
            min_d     = '1;
          end
        end
        PEAK: begin
          if (strobe) begin
            if (adc_data > max_q) max_d = adc_data;
            if (adc_data < min_q) min_d = adc_data;
            scnt_d = scnt_q + SCNT_W'(1);
            if (last_samp) state_d = CALC1;
          end
        end
        CALC1: begin
          vpp_int_d = max_q - min_q;
          dc_int_d  = ADC_W'(({1'b0, max_q} + {1'b0, min_q}) >> 1);
          sum_d     = '0;
          scnt_d    = '0;
          state_d   = RMS;
        end
        RMS: begin
          if (strobe) begin
            sum_d  = sum_q + SUM_W'($unsigned(sq));
            scnt_d = scnt_q + SCNT_W'(1);
            if (last_samp) state_d = CALC2;
          end
        end
        CALC2: begin
          ms_d = ms_now;
          if (ms_now == '0) begin
            res_d.vpp       = vpp_int_q;
            res_d.dc_offset = dc_int_q;
            res_d.mean_sq   = '0;
            res_d.papr      = '0;
            res_d.wave_type = WT_NONE;
            done_d          = 1'b1;
            state_d         = DONE;
          end else begin
            div_start_d = 1'b1;
            state_d     = DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            res_d.vpp       = vpp_int_q;
            res_d.dc_offset = dc_int_q;
            res_d.mean_sq   = ms_q;
            res_d.papr      = papr_sat;
            res_d.wave_type = classify(papr_sat, 1'b0, SQ_LO, SQ_HI,
                                       SINE_LO, SINE_HI, TRI_LO, TRI_HI);
            done_d          = 1'b1;
            state_d         = DONE;
          end
        end
        DONE: begin
`ifdef CONT_MEAS_EN
          state_d   = PEAK;
          stb_cnt_d = '0;
          scnt_d    = '0;
          max_d     = '0;
          min_d     = '1;
`else
          state_d   = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stb_cnt_q   <= '0;
      scnt_q      <= '0;
      max_q       <= '0;
      min_q       <= '0;
      vpp_int_q   <= '0;
      dc_int_q    <= '0;
      sum_q       <= '0;
      ms_q        <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_cnt_q   <= stb_cnt_d;
      scnt_q      <= scnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      vpp_int_q   <= vpp_int_d;
      dc_int_q    <= dc_int_d;
      sum_q       <= sum_d;
      ms_q        <= ms_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_start_q <= div_start_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign vpp       = res_q.vpp;
  assign dc_offset = res_q.dc_offset;
  assign mean_sq   = res_q.mean_sq;
  assign papr      = res_q.papr;
  assign wave_type = res_q.wave_type;

endmodule

// File: tb/tb_wave_measure_ctrl.sv
// Directed bench for wave_measure_ctrl with a short strobe period (FRE_DIV = 3).
// Honours CONT_MEAS_EN when the same macro is defined for the build.
`timescale 1ns/1ps
module tb_wave_measure_ctrl;

  localparam int unsigned FRE_DIV = 3;
  localparam int unsigned PER     = FRE_DIV + 1;
  localparam int unsigned LOG2_N  = 6;
  localparam int unsigned NS      = 1 << LOG2_N;
  localparam int          BUDGET  = 800;
`ifdef CONT_MEAS_EN
  localparam int          EXP_DONES = 2;
`else
  localparam int          EXP_DONES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  adc_data = 8'd0;
  logic        busy, done;
  logic [7:0]  vpp, dc_offset, papr;
  logic [15:0] mean_sq;
  logic [1:0]  wave_type;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pat      = 0;
  int done_cnt = 0;
  int div_starts = 0;
  logic [7:0] sine_tab [NS];

  wave_measure_ctrl #(.FRE_DIV(FRE_DIV), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .adc_data(adc_data),
    .busy(busy), .done(done), .vpp(vpp), .dc_offset(dc_offset),
    .mean_sq(mean_sq), .papr(papr), .wave_type(wave_type)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // One pattern value per strobe period; exact phase is irrelevant for full windows.
  always @(negedge clk) begin
    int s;
    s = cyc / PER;
    case (pat)
      0:       adc_data = (s % 2 == 1) ? 8'd200 : 8'd0;
      1:       adc_data = sine_tab[s % NS];
      default: adc_data = 8'd128;
    endcase
  end

  always @(negedge clk) begin
    if (done) done_cnt = done_cnt + 1;
    if (dut.div_start_q) div_starts = div_starts + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_meas();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic check_out(input string tag, input int e_vpp, input int e_dc,
                           input int e_ms, input int e_papr, input int e_wt);
    check({tag, "_vpp"},  32'(vpp),       32'(e_vpp));
    check({tag, "_dc"},   32'(dc_offset), 32'(e_dc));
    check({tag, "_ms"},   32'(mean_sq),   32'(e_ms));
    check({tag, "_papr"}, 32'(papr),      32'(e_papr));
    check({tag, "_wt"},   32'(wave_type), 32'(e_wt));
  endtask

  // Completes a measurement after its first done; continuous mode is stopped with abort.
  task automatic finish_meas(input string tag);
    int lat;
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
`ifdef CONT_MEAS_EN
    check({tag, "_busy_cont"}, 32'(busy), 32'd1);
    wait_done({tag, "_second"}, lat);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk) abort = 1'b0;
`endif
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, d0, s0, mx, mn, vm, dm, msm, pm, wm, sum;

    for (int i = 0; i < NS; i++)
      sine_tab[i] = 8'($rtoi(128.0 + 100.0 * $sin(2.0 * 3.14159265358979 * i / 64.0) + 0.5));
    mx = 0; mn = 255; sum = 0;
    for (int i = 0; i < NS; i++) begin
      if (int'(sine_tab[i]) > mx) mx = int'(sine_tab[i]);
      if (int'(sine_tab[i]) < mn) mn = int'(sine_tab[i]);
    end
    vm = mx - mn;
    dm = (mx + mn) / 2;
    for (int i = 0; i < NS; i++) sum = sum + (int'(sine_tab[i]) - dm) * (int'(sine_tab[i]) - dm);
    msm = sum / NS;
    pm = (vm * vm) / msm;
    if (pm > 255) pm = 255;
    wm = (pm >= 3 && pm <= 5) ? 2 : (pm >= 6 && pm <= 9) ? 1 : (pm >= 10 && pm <= 14) ? 3 : 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_out("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Square 0/200: vpp 200, dc 100, ms 10000, papr 40000/10000 = 4 -> square
    pat = 0;
    d0 = done_cnt;
    start_meas();
    wait_done("sq", lat);
    check("sq_latency_in_range", 32'(lat >= 525 && lat <= 540), 32'd1);
    check_out("sq", 200, 100, 10000, 4, 2);
    finish_meas("sq");
    repeat (5) @(posedge clk);
    check("sq_done_count", 32'(done_cnt - d0), 32'(EXP_DONES));

    // Sine, amplitude 100 around 128
    pat = 1;
    start_meas();
    wait_done("sine", lat);
    check("sine_vpp_200", 32'(vpp), 32'd200);
    check("sine_papr_7_to_9", 32'(papr >= 8'd7 && papr <= 8'd9), 32'd1);
    check_out("sine", vm, dm, msm, pm, wm);
    finish_meas("sine");

    // Constant 128: flat, divider must not be used
    pat = 2;
    s0 = div_starts;
    start_meas();
    wait_done("flat", lat);
    check_out("flat", 0, 128, 0, 0, 0);
    finish_meas("flat");
    check("flat_no_div_start", 32'(div_starts - s0), 32'd0);

    // Abort after 20 RMS strobes (samples on edges 4k; RMS 20th at edge 336)
    pat = 1;
    d0 = done_cnt;
    start_meas();
    repeat (335) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy_next_edge", 32'(busy), 32'd0);
    @(negedge clk) abort = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check_out("abort_hold", 0, 128, 0, 0, 0);

    // Restart after abort completes normally
    pat = 0;
    start_meas();
    wait_done("restart", lat);
    check_out("restart", 200, 100, 10000, 4, 2);
    finish_meas("restart");

    // start together with abort in IDLE is ignored
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_no_done", 32'(done_cnt - d0), 32'd0);
    check_out("start_abort_hold", 200, 100, 10000, 4, 2);

    // start while busy is ignored: single result, first schedule kept
    pat = 1;
    d0 = done_cnt;
    start_meas();
    repeat (100) @(posedge clk);
    start_meas();
    wait_done("busy_start", lat);
    check("busy_start_latency", 32'(lat + 101 >= 525 && lat + 101 <= 540), 32'd1);
    check_out("busy_start", vm, dm, msm, pm, wm);
    finish_meas("busy_start");
    repeat (5) @(posedge clk);
    check("busy_start_done_count", 32'(done_cnt - d0), 32'(EXP_DONES));

    // Asynchronous reset while the divider is running
    pat = 0;
    start_meas();
    repeat (520) @(posedge clk);
    #1;
    check("div_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check_out("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
